eject_inject_stage: RTL and testbench
=====================================

Name: eject_inject_stage

Overview:
- Router input stage that sits in front of the 4-port permutation network. It latches the four link flits and ejects at most one flit destined for this node to the local NI.
- It injects one pending NI flit into a free slot, ages all in-flight flits, and computes the per-port status vector that steers the permutation network.
- One pipeline stage; bufferless deflection router, so the links are never back-pressured.

Parameters:
- FLIT_W, 64, total flit width including header.
- COORD_W, 3, width of each X/Y coordinate field.
- AGE_W, 8, width of age field (saturating).
- FIFO_DEPTH, 4, injection FIFO entries (power of 2).
- LOCAL_X, 0, this router's X coordinate.
- LOCAL_Y, 0, this router's Y coordinate.

Flit layout (MSB down):
- valid [FLIT_W-1]
- age [FLIT_W-2 -: AGE_W]
- dst_x [next COORD_W]
- dst_y [next COORD_W]
- payload [remaining bits]

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- in_flit_e / in_flit_w / in_flit_n / in_flit_s  in  FLIT_W each  link flits; valid bit qualifies
- inj_flit  in  FLIT_W  NI injection data; valid/age bits ignored
- inj_valid  in  1  NI offers inj_flit
- inj_ready  out  1  FIFO not full
- ej_flit  out  FLIT_W  ejected flit
- ej_valid  out  1  one-cycle pulse, no back-pressure
- out_flit_e / out_flit_w / out_flit_n / out_flit_s  out  FLIT_W each  registered flits to permutation network
- port_status  out  12  3 bits per port {valid, dir[1:0]}, packed [S,N,W,E]; dir E=0, W=1, N=2, S=3
- fifo_count  out  log2(FIFO_DEPTH)+1  injection FIFO occupancy

Behaviour:
- Reset: all out_flit_*, ej_flit, ej_valid, port_status and fifo_count are 0; inj_ready is 1; FIFO pointers are 0. Reset asserted mid-operation drops all in-flight and queued flits.
- Latency: a link flit sampled at edge t appears on out_flit_* / ej_flit after edge t (1 cycle).
- Ejection: among valid inputs with dst == (LOCAL_X, LOCAL_Y), pick the largest age; ties go E > W > N > S. The selected flit drives ej_flit/ej_valid and its slot becomes empty. Other local-destined flits pass through (deflected).
- Injection: if the FIFO is non-empty and at least one slot is empty after ejection, pop the head into the first empty slot in order E, W, N, S. Injected flit: valid = 1, age = 0.
- A slot freed by ejection in the same cycle is eligible for injection.
- All 4 inputs valid with none ejected: no injection; the FIFO holds.
- Aging: every pass-through flit gets age+1, saturating at 2^AGE_W-1. Ejected flits are reported with their incoming age.
- Port status per valid output slot, X-first dimension order:
  - dst_x > LOCAL_X → E
  - dst_x < LOCAL_X → W
  - else dst_y > LOCAL_Y → N
  - else dst_y < LOCAL_Y → S
  - local (deflected) → E
- Empty slot: status 3'b000 and flit all zeros.
- FIFO:
  - Push when inj_valid && inj_ready; pop on injection.
  - inj_ready = (fifo_count < FIFO_DEPTH), combinational from the register.
  - Simultaneous push and pop keeps the count.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push when full is impossible (inj_ready = 0).
  - Pop when empty never occurs.
- Earliest injection: push at edge t into an empty FIFO → flit on out_flit_* after edge t+1.

Test Plan:
- Reset with all inputs driven → all outputs 0, inj_ready=1, fifo_count=0; deassert → first flit appears after 1 edge.
- LOCAL=(1,1); inputs E dst(3,1) age 5, N dst(1,0) age 2 → out_flit_e age 6 status {1,E}; out_flit_n age 3 status {1,S}; W/S slots 0.
- Two local flits: W age 7, S age 9 → ej_flit = S flit with age 9, ej_valid pulses for 1 cycle; W flit passes with age 8 and status {1,E}.
- Local flits on E and N with equal age 4 → E ejected.
- FIFO holds 1 entry; all 4 inputs valid, one local → injected flit placed in the ejected slot with age 0, fifo_count 1→0.
- Push 4 flits with all slots busy and none local → fifo_count=4, inj_ready=0; next cycle E input invalid → injected into E, fifo_count=3, inj_ready=1.
- Age 255 pass-through → stays 255.
- Assert reset_n=0 while FIFO holds 2 entries → fifo_count=0 asynchronously.

Source files
------------

// File: rtl/eject_inject_stage.sv
// Router input stage: latches four link flits, ejects one local flit, injects one NI flit, ages and steers.
// Latency: one cycle from link inputs / FIFO head to out_flit_*, ej_flit and port_status.
// Backpressure: links are never stalled (deflection); the NI is stalled only by inj_ready when the FIFO is full.
module eject_inject_stage #(
  parameter int FLIT_W     = 64,
  parameter int COORD_W    = 3,
  parameter int AGE_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int LOCAL_X    = 0,
  parameter int LOCAL_Y    = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [FLIT_W-1:0]             in_flit_e,
  input  logic [FLIT_W-1:0]             in_flit_w,
  input  logic [FLIT_W-1:0]             in_flit_n,
  input  logic [FLIT_W-1:0]             in_flit_s,
  input  logic [FLIT_W-1:0]             inj_flit,
  input  logic                          inj_valid,
  output logic                          inj_ready,
  output logic [FLIT_W-1:0]             ej_flit,
  output logic                          ej_valid,
  output logic [FLIT_W-1:0]             out_flit_e,
  output logic [FLIT_W-1:0]             out_flit_w,
  output logic [FLIT_W-1:0]             out_flit_n,
  output logic [FLIT_W-1:0]             out_flit_s,
  output logic [11:0]                   port_status,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PAY_W = FLIT_W - 1 - AGE_W - 2 * COORD_W;
  // Everything below the age field: destination plus payload, the part the NI supplies.
  localparam int INJ_W = FLIT_W - 1 - AGE_W;

  localparam logic [COORD_W-1:0] LX        = COORD_W'(LOCAL_X);
  localparam logic [COORD_W-1:0] LY        = COORD_W'(LOCAL_Y);
  localparam logic [CNT_W-1:0]   FIFO_FULL = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] DIR_E = 2'd0;
  localparam logic [1:0] DIR_W = 2'd1;
  localparam logic [1:0] DIR_N = 2'd2;
  localparam logic [1:0] DIR_S = 2'd3;

  typedef struct packed {
    logic               vld;
    logic [AGE_W-1:0]   age;
    logic [COORD_W-1:0] dstX;
    logic [COORD_W-1:0] dstY;
    logic [PAY_W-1:0]   payload;
  } flit_t;

  // X-first routing direction; a local destination means a deflected flit, sent E.
  function automatic logic [1:0] dirOf(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    if (x > LX)      dirOf = DIR_E;
    else if (x < LX) dirOf = DIR_W;
    else if (y > LY) dirOf = DIR_N;
    else if (y < LY) dirOf = DIR_S;
    else             dirOf = DIR_E;
  endfunction

  // Slot order everywhere: 0=E, 1=W, 2=N, 3=S.
  flit_t inF [4];
  assign inF[0] = in_flit_e;
  assign inF[1] = in_flit_w;
  assign inF[2] = in_flit_n;
  assign inF[3] = in_flit_s;

  // ---------------- injection FIFO ----------------
  logic [INJ_W-1:0] fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] fifoCnt;
  logic             pushVld;
  logic             popVld;
  logic             fifoNotEmpty;
  logic [INJ_W-1:0] fifoHead;
  logic             unusedInjHdr;

  // The NI's valid/age bits are overwritten on injection, so they are never stored.
  assign unusedInjHdr = ^inj_flit[FLIT_W-1:INJ_W];

  assign inj_ready    = (fifoCnt < FIFO_FULL);
  assign pushVld      = inj_valid && inj_ready;
  assign fifoNotEmpty = (fifoCnt != '0);
  assign fifoHead     = fifoMem[rdPtr];
  assign fifo_count   = fifoCnt;

  // Storage write; contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (pushVld) fifoMem[wrPtr] <= inj_flit[INJ_W-1:0];
  end

  // Pointers wrap naturally at the power-of-two depth; push+pop leaves the count unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      fifoCnt <= '0;
    end else begin
      if (pushVld) wrPtr <= wrPtr + PTR_W'(1);
      if (popVld)  rdPtr <= rdPtr + PTR_W'(1);
      case ({pushVld, popVld})
        2'b10:   fifoCnt <= fifoCnt + CNT_W'(1);
        2'b01:   fifoCnt <= fifoCnt - CNT_W'(1);
        default: fifoCnt <= fifoCnt;
      endcase
    end
  end

  // ---------------- ejection / injection / aging ----------------
  logic             ejHit;
  logic [1:0]       ejIdx;
  logic [AGE_W-1:0] ejAge;
  logic [3:0]       keep;
  logic             freeHit;
  logic [1:0]       injIdx;
  flit_t            nxtF [4];
  logic [11:0]      nxtStatus;
  flit_t            ejNxt;

  // Oldest local flit wins; strict '>' keeps the earlier slot on ties (E > W > N > S).
  always_comb begin
    ejHit = 1'b0;
    ejIdx = 2'd0;
    ejAge = '0;
    for (int i = 0; i < 4; i++) begin
      if (inF[i].vld && inF[i].dstX == LX && inF[i].dstY == LY && (!ejHit || inF[i].age > ejAge)) begin
        ejHit = 1'b1;
        ejIdx = 2'(i);
        ejAge = inF[i].age;
      end
    end
  end

  // Slots still occupied after ejection, and the first free one (a just-ejected slot counts as free).
  always_comb begin
    keep    = '0;
    freeHit = 1'b0;
    injIdx  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      keep[i] = inF[i].vld && !(ejHit && ejIdx == 2'(i));
    end
    for (int i = 0; i < 4; i++) begin
      if (!keep[i] && !freeHit) begin
        freeHit = 1'b1;
        injIdx  = 2'(i);
      end
    end
    popVld = freeHit && fifoNotEmpty;
  end

  // Next slot contents: aged pass-through, freshly injected flit, or all zeros.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      nxtF[i] = '0;
      if (keep[i]) begin
        nxtF[i]     = inF[i];
        nxtF[i].age = (inF[i].age == '1) ? inF[i].age : inF[i].age + AGE_W'(1);
      end else if (popVld && injIdx == 2'(i)) begin
        nxtF[i].vld = 1'b1;
        nxtF[i].age = '0;
        {nxtF[i].dstX, nxtF[i].dstY, nxtF[i].payload} = fifoHead;
      end
    end
  end

  // Per-slot steering status {valid, dir}, packed [S,N,W,E]; empty slots report zero.
  always_comb begin
    nxtStatus = '0;
    for (int i = 0; i < 4; i++) begin
      if (nxtF[i].vld) nxtStatus[3*i +: 3] = {1'b1, dirOf(nxtF[i].dstX, nxtF[i].dstY)};
    end
  end

  // Ejected flit keeps its incoming age; the port reads zero when nothing is ejected.
  always_comb begin
    ejNxt = '0;
    if (ejHit) ejNxt = inF[ejIdx];
  end

  // ---------------- output registers ----------------
  flit_t       outQ [4];
  flit_t       ejQ;
  logic        ejValidQ;
  logic [11:0] statusQ;

  // Single pipeline stage; reset empties every slot and cancels any ejection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) outQ[i] <= '0;
      ejQ      <= '0;
      ejValidQ <= 1'b0;
      statusQ  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) outQ[i] <= nxtF[i];
      ejQ      <= ejNxt;
      ejValidQ <= ejHit;
      statusQ  <= nxtStatus;
    end
  end

  assign out_flit_e  = outQ[0];
  assign out_flit_w  = outQ[1];
  assign out_flit_n  = outQ[2];
  assign out_flit_s  = outQ[3];
  assign ej_flit     = ejQ;
  assign ej_valid    = ejValidQ;
  assign port_status = statusQ;

endmodule

// File: tb/tb_eject_inject_stage.sv
// Scoreboard bench for eject_inject_stage with LOCAL=(1,1): directed cases then randomized traffic.
// Reference model works on whole flits and a queue standing in for the injection FIFO.
// Monitor compares every registered output one cycle after each stimulus cycle.
module tb_eject_inject_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] inE, inW, inN, inS, injFlit;
  logic        injValid;
  logic        injReady;
  logic [63:0] ejFlit, outE, outW, outN, outS;
  logic        ejValid;
  logic [11:0] portStatus;
  logic [2:0]  fifoCount;

  always #5 clk = ~clk;

  eject_inject_stage #(
    .FLIT_W(64), .COORD_W(3), .AGE_W(8), .FIFO_DEPTH(4), .LOCAL_X(1), .LOCAL_Y(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_flit_e(inE), .in_flit_w(inW), .in_flit_n(inN), .in_flit_s(inS),
    .inj_flit(injFlit), .inj_valid(injValid), .inj_ready(injReady),
    .ej_flit(ejFlit), .ej_valid(ejValid),
    .out_flit_e(outE), .out_flit_w(outW), .out_flit_n(outN), .out_flit_s(outS),
    .port_status(portStatus), .fifo_count(fifoCount)
  );

  typedef struct packed {
    logic [3:0][63:0] o;
    logic [11:0]      st;
    logic [63:0]      ej;
    logic             ejv;
    logic [2:0]       cnt;
  } exp_t;

  exp_t        sbq[$];
  logic [54:0] mq[$];
  int          nTests = 0;
  int          nFail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    nTests++;
    if (act !== req) begin
      nFail++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Flit layout: valid[63] age[62:55] dst_x[54:52] dst_y[51:49] payload[48:0]
  function automatic logic [63:0] mk(input logic v, input logic [7:0] a, input logic [2:0] x,
                                     input logic [2:0] y, input logic [48:0] p);
    return {v, a, x, y, p};
  endfunction

  function automatic logic [63:0] rndFlit();
    logic [63:0] f;
    f = {$urandom, $urandom};
    f[63]    = ($urandom_range(0, 9) < 7);
    f[54:52] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
    f[51:49] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
    if ($urandom_range(0, 7) == 0) f[62:55] = 8'hFF;
    return f;
  endfunction

  task automatic idle();
    inE = '0; inW = '0; inN = '0; inS = '0; injFlit = '0; injValid = 1'b0;
  endtask

  // Drive one cycle of stimulus, predict the registered result, then advance past the edge.
  task automatic step(input logic [63:0] e, input logic [63:0] w, input logic [63:0] n,
                      input logic [63:0] s, input logic iv, input logic [63:0] idat);
    logic [63:0] f[4];
    exp_t        x;
    int          best;
    bit          rdy;
    bit          injd;
    logic [1:0]  d;
    @(negedge clk);
    inE = e; inW = w; inN = n; inS = s; injValid = iv; injFlit = idat;
    f[0] = e; f[1] = w; f[2] = n; f[3] = s;
    x    = '0;
    best = -1;
    rdy  = (mq.size() < 4);
    for (int i = 0; i < 4; i++) begin
      if (!f[i][63]) f[i] = '0;
      else if (f[i][54:52] == 3'd1 && f[i][51:49] == 3'd1) begin
        if (best < 0) best = i;
        else if (f[i][62:55] > f[best][62:55]) best = i;
      end
    end
    if (best >= 0) begin
      x.ej  = f[best];
      x.ejv = 1'b1;
      f[best] = '0;
    end
    for (int i = 0; i < 4; i++)
      if (f[i][63]) f[i][62:55] = (f[i][62:55] == 8'hFF) ? 8'hFF : f[i][62:55] + 8'd1;
    injd = 1'b0;
    if (mq.size() > 0)
      for (int i = 0; i < 4; i++)
        if (!injd && !f[i][63]) begin
          f[i] = {1'b1, 8'd0, mq.pop_front()};
          injd = 1'b1;
        end
    for (int i = 0; i < 4; i++) begin
      x.o[i] = f[i];
      if (f[i][63]) begin
        if (f[i][54:52] > 3'd1)      d = 2'd0;
        else if (f[i][54:52] < 3'd1) d = 2'd1;
        else if (f[i][51:49] > 3'd1) d = 2'd2;
        else if (f[i][51:49] < 3'd1) d = 2'd3;
        else                         d = 2'd0;
        x.st[3*i +: 3] = {1'b1, d};
      end
    end
    if (iv && rdy) mq.push_back(idat[54:0]);
    x.cnt = 3'(mq.size());
    sbq.push_back(x);
    @(posedge clk);
    #3;
  endtask

  // Monitor: one expectation per stimulus cycle, checked just after the edge that produced it.
  initial begin
    forever begin : mon
      exp_t x;
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        x = sbq.pop_front();
        chk("sb_out_e", outE, x.o[0]);
        chk("sb_out_w", outW, x.o[1]);
        chk("sb_out_n", outN, x.o[2]);
        chk("sb_out_s", outS, x.o[3]);
        chk("sb_status", 64'(portStatus), 64'(x.st));
        chk("sb_ej_valid", 64'(ejValid), 64'(x.ejv));
        if (x.ejv) chk("sb_ej_flit", ejFlit, x.ej);
        chk("sb_fifo_count", 64'(fifoCount), 64'(x.cnt));
        chk("sb_inj_ready", 64'(injReady), 64'(x.cnt < 3'd4));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout tests=%0d", nTests);
    $fatal(1);
  end

  logic [63:0] busyA, busyB, busyC, busyD, injX, firstPush;

  initial begin
    // Reset while inputs are busy: everything must stay cleared.
    reset_n = 1'b0;
    inE = rndFlit(); inW = rndFlit(); inN = rndFlit(); inS = rndFlit();
    injFlit = rndFlit(); injValid = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_out_e", outE, 64'd0);
    chk("rst_out_w", outW, 64'd0);
    chk("rst_out_n", outN, 64'd0);
    chk("rst_out_s", outS, 64'd0);
    chk("rst_ej_flit", ejFlit, 64'd0);
    chk("rst_ej_valid", 64'(ejValid), 64'd0);
    chk("rst_status", 64'(portStatus), 64'd0);
    chk("rst_fifo_count", 64'(fifoCount), 64'd0);
    chk("rst_inj_ready", 64'(injReady), 64'd1);
    @(negedge clk);
    idle();
    reset_n = 1'b1;

    // Pass-through aging and X-first steering.
    step(mk(1, 5, 3, 1, 49'h11), '0, mk(1, 2, 1, 0, 49'h22), '0, 1'b0, '0);
    chk("d1_out_e", outE, mk(1, 6, 3, 1, 49'h11));
    chk("d1_out_n", outN, mk(1, 3, 1, 0, 49'h22));
    chk("d1_out_w", outW, 64'd0);
    chk("d1_status", 64'(portStatus), 64'(12'b000_111_000_100));

    // Oldest local flit ejected, the other deflected east.
    step('0, mk(1, 7, 1, 1, 49'h33), '0, mk(1, 9, 1, 1, 49'h44), 1'b0, '0);
    chk("d2_ej_flit", ejFlit, mk(1, 9, 1, 1, 49'h44));
    chk("d2_ej_valid", 64'(ejValid), 64'd1);
    chk("d2_out_w", outW, mk(1, 8, 1, 1, 49'h33));
    chk("d2_status", 64'(portStatus), 64'(12'b000_000_100_000));
    step('0, '0, '0, '0, 1'b0, '0);
    chk("d2_ej_pulse", 64'(ejValid), 64'd0);

    // Equal-age tie goes to E.
    step(mk(1, 4, 1, 1, 49'h55), '0, mk(1, 4, 1, 1, 49'h66), '0, 1'b0, '0);
    chk("d3_ej_tie", ejFlit, mk(1, 4, 1, 1, 49'h55));

    // Saturated age.
    step(mk(1, 255, 3, 1, 49'h77), '0, '0, '0, 1'b0, '0);
    chk("d4_age_sat", outE, mk(1, 255, 3, 1, 49'h77));

    // One queued flit fills the slot freed by ejection.
    busyA = mk(1, 1, 0, 0, 49'hA); busyB = mk(1, 1, 2, 2, 49'hB);
    busyC = mk(1, 1, 0, 2, 49'hC); busyD = mk(1, 1, 2, 0, 49'hD);
    injX  = mk(0, 8'h5A, 2, 1, 49'h1_2345);
    step(busyA, busyB, busyC, busyD, 1'b1, injX);
    chk("d5_count1", 64'(fifoCount), 64'd1);
    step(busyA, mk(1, 3, 1, 1, 49'hE), busyC, busyD, 1'b0, '0);
    chk("d5_inj_slot", outW, {1'b1, 8'd0, injX[54:0]});
    chk("d5_count0", 64'(fifoCount), 64'd0);

    // Fill the FIFO while every slot is busy, then open E.
    firstPush = rndFlit();
    step(busyA, busyB, busyC, busyD, 1'b1, firstPush);
    repeat (3) step(busyA, busyB, busyC, busyD, 1'b1, rndFlit());
    chk("d6_full_count", 64'(fifoCount), 64'd4);
    chk("d6_full_ready", 64'(injReady), 64'd0);
    step('0, busyB, busyC, busyD, 1'b1, rndFlit());
    chk("d6_inj_e", outE, {1'b1, 8'd0, firstPush[54:0]});
    chk("d6_count3", 64'(fifoCount), 64'd3);
    chk("d6_ready", 64'(injReady), 64'd1);

    // Asynchronous reset with two queued entries.
    step('0, '0, '0, '0, 1'b0, '0);
    chk("d7_count2", 64'(fifoCount), 64'd2);
    #1;
    reset_n = 1'b0;
    #1;
    chk("d7_arst_count", 64'(fifoCount), 64'd0);
    chk("d7_arst_ready", 64'(injReady), 64'd1);
    chk("d7_arst_out_e", outE, 64'd0);
    chk("d7_arst_status", 64'(portStatus), 64'd0);
    mq.delete();
    sbq.delete();
    @(negedge clk);
    idle();
    reset_n = 1'b1;

    // Randomized traffic.
    repeat (3000) step(rndFlit(), rndFlit(), rndFlit(), rndFlit(), 1'($urandom_range(0, 1)), rndFlit());
    @(posedge clk);
    #3;
    chk("sb_drained", 64'(sbq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
